// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data RAM between the CPU load/store path and a
// HOST/debug port. Accesses run through IDLE -> ACCESS -> WAIT -> ACK, and
// read data returns in a holding register for each requester.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break ties round-robin.
// If it is undefined, the CPU wins every tie.
module mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          tie_host;
    logic          grant_host;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, grant the port that was not granted last.
    assign tie_host = ~owner_q;
`else
    // On a tie, the CPU always wins.
    assign tie_host = 1'b0;
`endif

    // A port that requests alone always wins. The tie rule applies only when both request.
    assign grant_host = host_req & (~cpu_req | tie_host);

    // Next-state logic: the sequencer, the request latch in IDLE, and the read capture in WAIT.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req | host_req) begin
                    owner_d = grant_host;
                    we_d    = grant_host ? host_we    : cpu_we;
                    addr_d  = grant_host ? host_addr  : cpu_addr;
                    wdata_d = grant_host ? host_wdata : cpu_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_WAIT;
            S_WAIT: begin
                if (!we_q) begin
                    if (owner_q) host_rdata_d = mem_rdata;
                    else         cpu_rdata_d  = mem_rdata;
                end
                state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and holding registers. Reset drops any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // The strobes and acks are decoded straight from the state register.
    // An asynchronous reset therefore cuts off a write in ACCESS at once.
    assign mem_we     = (state_q == S_ACCESS) &  we_q;
    assign mem_re     = (state_q == S_ACCESS) & ~we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_ack    = (state_q == S_ACK) & ~owner_q;
    assign host_ack   = (state_q == S_ACK) &  owner_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign owner      = owner_q;
    assign cpu_stall  = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test bench for mem_arbiter with a small RAM model.
// An unwritten RAM word reads back as 0xA5000000 | addr.
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          cpu_ack, cpu_stall, host_ack, mem_we, mem_re, owner;
    logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // RAM model: read data is valid in the cycle after mem_re.
    logic [DW-1:0] ram [1024];
    bit            ram_vld [1024];

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        return ram_vld[a] ? ram[a] : (32'hA500_0000 | {22'd0, a});
    endfunction

    // RAM model: writes on mem_we, and registers read data on mem_re.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            ram_vld[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= ram_rd(mem_addr);
    end

    // Bus monitor: samples on the falling edge and counts strobes, acks and stall cycles.
    int            n_we = 0, n_re = 0, n_cack = 0, n_hack = 0, n_stall = 0;
    logic [AW-1:0] we_addr = '0, re_addr = '0;
    logic [DW-1:0] we_data = '0;
    logic [7:0]    gord = '0;
    always @(negedge clk) begin
        if (mem_we) begin n_we <= n_we + 1; we_addr <= mem_addr; we_data <= mem_wdata; end
        if (mem_re) begin n_re <= n_re + 1; re_addr <= mem_addr; end
        if (cpu_ack)  n_cack <= n_cack + 1;
        if (host_ack) n_hack <= n_hack + 1;
        if (cpu_ack | host_ack) gord <= {gord[6:0], host_ack};
        if (cpu_stall) n_stall <= n_stall + 1;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits up to 10 cycles for the selected port's ack.
    // Returns the number of cycles waited, or -1 on timeout.
    task automatic wait_ack(input bit host, output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 10 && !found; i++) begin
            step();
            #1;
            if (host ? host_ack : cpu_ack) begin
                lat   = i;
                found = 1'b1;
            end
        end
    endtask

    initial begin
        int lat;
        int b_we, b_re, b_ca, b_ha, b_st;

        // Reset values.
        repeat (3) step();
        #1;
        chk("rst_cpu_ack",    32'(cpu_ack),    0);
        chk("rst_host_ack",   32'(host_ack),   0);
        chk("rst_mem_we",     32'(mem_we),     0);
        chk("rst_mem_re",     32'(mem_re),     0);
        chk("rst_mem_addr",   32'(mem_addr),   0);
        chk("rst_mem_wdata",  mem_wdata,       0);
        chk("rst_cpu_rdata",  cpu_rdata,       0);
        chk("rst_host_rdata", host_rdata,      0);
        chk("rst_owner",      32'(owner),      1);
        step(); reset = 1'b1;
        step();

        // CPU write of 0xDEADBEEF to address 0x005.
        b_we = n_we; b_ha = n_hack;
        step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF; #1;
        chk("wr_stall_req", 32'(cpu_stall), 1);
        wait_ack(1'b0, lat);
        chk("wr_latency", lat, 3);
        chk("wr_stall_ack", 32'(cpu_stall), 0);
        step(); cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        chk("wr_we_count", n_we - b_we, 1);
        chk("wr_we_addr", 32'(we_addr), 32'h005);
        chk("wr_we_data", we_data, 32'hDEADBEEF);
        chk("wr_host_ack", n_hack - b_ha, 0);

        // CPU read of address 0x005.
        b_we = n_we; b_re = n_re; b_st = n_stall;
        step(); cpu_req = 1'b1; cpu_addr = 10'h005; #1;
        wait_ack(1'b0, lat);
        chk("rd_latency", lat, 3);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_host_rdata", host_rdata, 0);
        step(); cpu_req = 1'b0;
        chk("rd_re_count", n_re - b_re, 1);
        chk("rd_we_count", n_we - b_we, 0);
        chk("rd_stall_cycles", n_stall - b_st, 3);

        // The HOST address changes during ACCESS. The RAM must still see the latched address.
        b_re = n_re;
        step(); host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010; #1;
        step(); host_addr = 10'h020; #1;
        chk("hchg_mem_re", 32'(mem_re), 1);
        chk("hchg_mem_addr", 32'(mem_addr), 32'h010);
        wait_ack(1'b1, lat);
        chk("hchg_latency", lat + 1, 3);
        chk("hchg_host_rdata", host_rdata, 32'hA500_0010);
        chk("hchg_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        step(); host_req = 1'b0; host_addr = 10'h010;
        chk("hchg_re_count", n_re - b_re, 1);
        chk("hchg_re_addr", 32'(re_addr), 32'h010);

        // Both ports hold read requests for 16 cycles. The HOST was granted last.
        b_ca = n_cack; b_ha = n_hack;
        for (int i = 0; i < 16; i++) begin
            step();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h001;
            host_req = 1'b1; host_we = 1'b0; host_addr = 10'h002;
        end
        step(); cpu_req = 1'b0; host_req = 1'b0; #1;
        chk("cont_cpu_rdata", cpu_rdata, 32'hA500_0001);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("cont_cpu_acks", n_cack - b_ca, 2);
        chk("cont_host_acks", n_hack - b_ha, 2);
        chk("cont_order", 32'(gord[3:0]), 32'b0101);
        chk("cont_host_rdata", host_rdata, 32'hA500_0002);
        chk("cont_owner", 32'(owner), 1);
`else
        chk("cont_cpu_acks", n_cack - b_ca, 4);
        chk("cont_host_acks", n_hack - b_ha, 0);
        chk("cont_order", 32'(gord[3:0]), 32'b0000);
        chk("cont_host_rdata", host_rdata, 32'hA500_0010);
        chk("cont_owner", 32'(owner), 0);
`endif

        // Reset is asserted in the WAIT cycle of a CPU read.
        b_ca = n_cack;
        step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005; #1;
        step(); #1;
        chk("arst_access_re", 32'(mem_re), 1);
        step(); reset = 1'b0; cpu_req = 1'b0; #1;
        chk("arst_cpu_ack", 32'(cpu_ack), 0);
        chk("arst_cpu_rdata", cpu_rdata, 0);
        chk("arst_mem_re", 32'(mem_re), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_owner", 32'(owner), 1);
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("arst_no_ack", n_cack - b_ca, 0);
        step(); host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010; #1;
        wait_ack(1'b1, lat);
        chk("arst_host_latency", lat, 3);
        chk("arst_host_rdata", host_rdata, 32'hA500_0010);
        chk("arst_host_cpu_ack", 32'(cpu_ack), 0);
        step(); host_req = 1'b0;

        // The CPU holds its request one cycle past the ack. This causes a second access.
        b_re = n_re; b_ca = n_cack;
        step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h007; #1;
        wait_ack(1'b0, lat);
        chk("viol_first_latency", lat, 3);
        step(); #1;
        chk("viol_stall_idle", 32'(cpu_stall), 1);
        step(); cpu_req = 1'b0; #1;
        wait_ack(1'b0, lat);
        chk("viol_second_gap", lat + 2, 4);
        step();
        chk("viol_re_count", n_re - b_re, 2);
        chk("viol_ack_count", n_cack - b_ca, 2);
        chk("viol_re_addr", 32'(re_addr), 32'h007);
        chk("viol_cpu_rdata", cpu_rdata, 32'hA500_0007);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
